// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Iteration counter must hold values 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int D = 16
) (
  input  logic [D:0]   rem_i,
  input  logic         bit_i,
  input  logic [D-1:0] dvs_i,
  output logic [D:0]   rem_o,
  output logic         q_o
);

  logic [D+1:0] shifted;

  always_comb begin
    shifted = {rem_i, bit_i};
    q_o     = (shifted >= {2'b00, dvs_i});
    rem_o   = q_o ? (shifted[D:0] - {1'b0, dvs_i}) : shifted[D:0];
  end

endmodule

// File: rtl/seq_div.sv
// Multi-cycle restoring divider, unsigned or signed per operation, one quotient bit per clock.
// Divide-by-zero and signed-overflow cases bypass the iteration and finish in two edges.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int N = 32,
  parameter int D = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         signed_op,
  input  logic [N-1:0] dividend,
  input  logic [D-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [D-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int CW = cnt_width(N);
  localparam logic [N-1:0] MIN_N = {1'b1, {(N-1){1'b0}}};

  state_e       state_q;
  logic         busy_q, done_q;
  logic [N-1:0] dvd_q;
  logic [D:0]   rem_q;
  logic [D-1:0] dvs_q;
  logic [CW-1:0] cnt_q;
  logic         sq_q, sr_q;
  logic         dbz_pend_q, ovf_pend_q;
  logic [N-1:0] quo_q;
  logic [D-1:0] remo_q;
  logic         dbz_q, ovf_q;

  logic         a_neg, b_neg, b_zero, is_ovf;
  logic [N-1:0] a_abs;
  logic [D-1:0] b_abs;
  logic [D:0]   step_rem;
  logic         step_q;
  logic [N-1:0] quo_d;
  logic [D-1:0] rem_d;

  always_comb begin
    a_neg  = signed_op & dividend[N-1];
    b_neg  = signed_op & divisor[D-1];
    a_abs  = a_neg ? -dividend : dividend;
    b_abs  = b_neg ? -divisor : divisor;
    b_zero = (divisor == '0);
    is_ovf = signed_op && (dividend == MIN_N) && (divisor == '1);
    // Final remainder is below the divisor, so its low D bits carry the whole value.
    quo_d  = sq_q ? -dvd_q : dvd_q;
    rem_d  = sr_q ? -rem_q[D-1:0] : rem_q[D-1:0];
  end

  div_step #(.D(D)) u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[N-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dvd_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      sq_q       <= 1'b0;
      sr_q       <= 1'b0;
      dbz_pend_q <= 1'b0;
      ovf_pend_q <= 1'b0;
      quo_q      <= '0;
      remo_q     <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            busy_q     <= 1'b1;
            rem_q      <= '0;
            cnt_q      <= '0;
            dvs_q      <= b_abs;
            sq_q       <= a_neg ^ b_neg;
            sr_q       <= a_neg;
            dbz_pend_q <= b_zero;
            ovf_pend_q <= is_ovf;
            // Shortcuts keep the raw dividend; FIX builds their results from it.
            if (b_zero || is_ovf) begin
              dvd_q   <= dividend;
              state_q <= FIX;
            end else begin
              dvd_q   <= a_abs;
              state_q <= CALC;
            end
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        CALC: begin
          dvd_q <= {dvd_q[N-2:0], step_q};
          rem_q <= step_rem;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          if (dbz_pend_q) begin
            quo_q  <= '1;
            remo_q <= dvd_q[D-1:0];
          end else if (ovf_pend_q) begin
            quo_q  <= dvd_q;
            remo_q <= '0;
          end else begin
            quo_q  <= quo_d;
            remo_q <= rem_d;
          end
          dbz_q   <= dbz_pend_q;
          ovf_q   <= ovf_pend_q;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div with N=32, D=16.
module tb_seq_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy, done, div_by_zero, overflow;
  logic [31:0] quotient;
  logic [15:0] remainder;

  int n_chk  = 0;
  int n_pass = 0;
  int lat, bcyc;

  seq_div #(.N(32), .D(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drive operands now, let the next rising edge accept them.
  task automatic launch(input logic sop, input logic [31:0] a, input logic [15:0] b);
    signed_op = sop;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called #1 after the accepting edge; counts edges up to done and busy cycles.
  task automatic wait_done(output int l, output int bc);
    l  = 0;
    bc = busy ? 1 : 0;
    while (!done && l < 100) begin
      @(posedge clk);
      #1;
      l++;
      if (busy) bc++;
    end
  endtask

  task automatic do_op(input logic sop, input logic [31:0] a, input logic [15:0] b);
    @(negedge clk);
    launch(sop, a, b);
    wait_done(lat, bcyc);
  endtask

  task automatic chk_res(input string tag, input int exp_lat, input logic [31:0] q,
                         input logic [15:0] r, input logic [1:0] flags);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_q"}, 64'(quotient), 64'(q));
    chk({tag, "_r"}, 64'(remainder), 64'(r));
    chk({tag, "_flags"}, 64'({div_by_zero, overflow}), 64'(flags));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_q", 64'(quotient), 64'd0);
    chk("rst_flags", 64'({div_by_zero, overflow}), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // 100000 / 7 unsigned: 14285 r 5, 33 edges, busy 33 cycles.
    do_op(1'b0, 32'd100000, 16'd7);
    chk_res("u100000_7", 33, 32'd14285, 16'd5, 2'b00);
    chk("u100000_7_busy", 64'(bcyc), 64'd33);
    @(posedge clk); #1;
    chk("done_pulse_one", 64'(done), 64'd0);
    chk("hold_q", 64'(quotient), 64'd14285);

    // -100 / 7 signed: -14 r -2; same bits unsigned: 4294967196/7 = 613566742 r 2.
    do_op(1'b1, 32'hFFFFFF9C, 16'd7);
    chk_res("s_m100_7", 33, 32'hFFFFFFF2, 16'hFFFE, 2'b00);
    do_op(1'b0, 32'hFFFFFF9C, 16'd7);
    chk_res("u_ff9c_7", 33, 32'h24924916, 16'h0002, 2'b00);

    // Signed negative divisor: 100 / -7 = -14 r 2.
    do_op(1'b1, 32'd100, 16'hFFF9);
    chk_res("s_100_m7", 33, 32'hFFFFFFF2, 16'h0002, 2'b00);

    // Divide by zero shortcut.
    do_op(1'b0, 32'h12345678, 16'h0000);
    chk_res("dbz", 1, 32'hFFFFFFFF, 16'h5678, 2'b10);
    chk("dbz_busy", 64'(bcyc), 64'd1);

    // Signed overflow shortcut, then unsigned max / 1.
    do_op(1'b1, 32'h80000000, 16'hFFFF);
    chk_res("ovf", 1, 32'h80000000, 16'h0000, 2'b01);
    do_op(1'b0, 32'hFFFFFFFF, 16'd1);
    chk_res("umax_1", 33, 32'hFFFFFFFF, 16'h0000, 2'b00);

    // Start pulsed mid-CALC is ignored: 1000 / 10 must complete untouched.
    @(negedge clk);
    launch(1'b0, 32'd1000, 16'd10);
    repeat (5) @(posedge clk);
    @(negedge clk);
    dividend = 32'd50; divisor = 16'd5; start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(lat, bcyc);
    lat = lat + 6;
    chk_res("ign_start", 33, 32'd100, 16'd0, 2'b00);

    // Start held in the done cycle is accepted back-to-back.
    launch(1'b0, 32'd50, 16'd5);
    wait_done(lat, bcyc);
    chk_res("b2b", 33, 32'd10, 16'd0, 2'b00);

    // Async reset 10 cycles into CALC clears everything at once.
    @(negedge clk);
    launch(1'b0, 32'd9999, 16'd3);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_q", 64'(quotient), 64'd0);
    chk("arst_r", 64'(remainder), 64'd0);
    chk("arst_flags", 64'({div_by_zero, overflow}), 64'd0);
    @(negedge clk) rst = 1'b0;
    do_op(1'b0, 32'd9, 16'd4);
    chk_res("post_rst", 33, 32'd2, 16'd1, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
